nukv_rotation_stream: RTL and testbench

- Streaming fixed-point 3D (generally COL_COUNT-D) rotation engine for the value path of the privacy pipeline.
- Each packet's header words pass through unchanged. Every body word carries LANES packed vectors, and each vector is multiplied by the active COL_COUNT×COL_COUNT matrix.
- Adds over the previous rotation datapath: multiple lanes per word, per-packet matrix latching with a shadow register, per-packet bypass, saturation, full backpressure, and status counters.

---
 rtl/nukv_rotation_stream.sv | 189 ++++++++++++++++++
 tb/tb_nukv_rotation_stream.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nukv_rotation_stream.sv
// Streaming COL_COUNT-D fixed-point rotation: header words pass through, body lanes are multiplied by the active matrix.
// Latency: 2 cycles (products registered, then sum/shift/saturate registered); 1 word/cycle sustained.
// Backpressure: whole pipeline stalls when output is held; input_ready = !output_valid || output_ready.
module nukv_rotation_stream #(
  parameter int MEMORY_WIDTH = 512,
  parameter int COL_COUNT    = 3,
  parameter int COL_WIDTH    = 64,
  parameter int FRAC_BITS    = 16,
  parameter int LANES        = MEMORY_WIDTH / (COL_COUNT * COL_WIDTH),
  parameter int HEADER_WORDS = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [COL_COUNT*COL_COUNT*COL_WIDTH-1:0]   matrix_data,
  input  logic                                       matrix_valid,
  input  logic                                       bypass,
  input  logic [MEMORY_WIDTH-1:0]                    input_data,
  input  logic                                       input_valid,
  input  logic                                       input_last,
  output logic                                       input_ready,
  output logic [MEMORY_WIDTH-1:0]                    output_data,
  output logic                                       output_valid,
  output logic                                       output_last,
  input  logic                                       output_ready,
  output logic [31:0]                                pkt_count,
  output logic                                       sat_flag
);

  localparam int MAT_W  = COL_COUNT * COL_COUNT * COL_WIDTH;
  localparam int PROD_W = 2 * COL_WIDTH;
  localparam int SUM_W  = PROD_W + $clog2(COL_COUNT);
  localparam int HCW    = (HEADER_WORDS > 1) ? $clog2(HEADER_WORDS + 1) : 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-COL_WIDTH+1){1'b0}}, {(COL_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-COL_WIDTH+1){1'b1}}, {(COL_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ST_START, ST_HDR, ST_BODY} state_t;

  function automatic logic [MAT_W-1:0] identity_matrix();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < COL_COUNT; i++)
      m[(i*COL_COUNT+i)*COL_WIDTH +: COL_WIDTH] = {{(COL_WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS;
    return m;
  endfunction

  logic [MAT_W-1:0]        pending;
  logic [MAT_W-1:0]        active;
  state_t                  state;
  logic [HCW-1:0]          hdr_cnt;
  logic                    pkt_bypass;
  logic                    adv;
  logic                    accept;
  logic                    word_rot;

  logic                    s1_valid;
  logic                    s1_rot;
  logic                    s1_last;
  logic [MEMORY_WIDTH-1:0] s1_data;
  logic signed [PROD_W-1:0] s1_prod [LANES][COL_COUNT][COL_COUNT];
  logic                    s2_sat;

  logic [MEMORY_WIDTH-1:0] rot_data;
  logic                    any_sat;
  logic signed [SUM_W-1:0] acc;
  logic signed [SUM_W-1:0] shifted;

  assign adv         = !output_valid || output_ready;
  assign input_ready = adv;
  assign accept      = input_valid && adv;
  assign word_rot    = (state == ST_BODY) && !pkt_bypass;

  // Packet framing: track first word, remaining header words and body.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_START;
      hdr_cnt    <= '0;
      pkt_bypass <= 1'b0;
    end else if (accept) begin
      unique case (state)
        ST_START: begin
          pkt_bypass <= bypass;
          hdr_cnt    <= HCW'(1);
          if (input_last)            state <= ST_START;
          else if (HEADER_WORDS > 1) state <= ST_HDR;
          else                       state <= ST_BODY;
        end
        ST_HDR: begin
          hdr_cnt <= hdr_cnt + HCW'(1);
          if (input_last)                             state <= ST_START;
          else if (hdr_cnt == HCW'(HEADER_WORDS - 1)) state <= ST_BODY;
        end
        ST_BODY: begin
          if (input_last) state <= ST_START;
        end
        default: state <= ST_START;
      endcase
    end
  end

  // Shadow matrix: strobes land in pending; active only changes on a packet's first word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= identity_matrix();
      active  <= identity_matrix();
    end else begin
      if (matrix_valid) pending <= matrix_data;
      if (accept && state == ST_START) active <= pending;
    end
  end

  // Stage 1: register every lane product plus the word's metadata.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rot   <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
    end else if (adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_rot  <= word_rot;
        s1_last <= input_last;
        s1_data <= input_data;
        for (int l = 0; l < LANES; l++)
          for (int i = 0; i < COL_COUNT; i++)
            for (int j = 0; j < COL_COUNT; j++)
              s1_prod[l][i][j] <=
                PROD_W'($signed(active[(i*COL_COUNT+j)*COL_WIDTH +: COL_WIDTH])) *
                PROD_W'($signed(input_data[(l*COL_COUNT+j)*COL_WIDTH +: COL_WIDTH]));
      end
    end
  end

  // Full-precision row sums, arithmetic shift (floor), clamp to element range.
  always_comb begin
    rot_data = s1_data;
    any_sat  = 1'b0;
    acc      = '0;
    shifted  = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < COL_COUNT; i++) begin
        acc = '0;
        for (int j = 0; j < COL_COUNT; j++)
          acc = acc + SUM_W'(s1_prod[l][i][j]);
        shifted = acc >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
          shifted = SAT_MAX;
          any_sat = 1'b1;
        end else if (shifted < SAT_MIN) begin
          shifted = SAT_MIN;
          any_sat = 1'b1;
        end
        rot_data[(l*COL_COUNT+i)*COL_WIDTH +: COL_WIDTH] = shifted[COL_WIDTH-1:0];
      end
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      output_valid <= 1'b0;
      output_last  <= 1'b0;
      output_data  <= '0;
      s2_sat       <= 1'b0;
    end else if (adv) begin
      output_valid <= s1_valid;
      output_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        output_data <= s1_rot ? rot_data : s1_data;
        s2_sat      <= s1_rot && any_sat;
      end
    end
  end

  // Status: completed-packet counter and sticky saturation flag, updated on output transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
      sat_flag  <= 1'b0;
    end else if (output_valid && output_ready) begin
      if (output_last) pkt_count <= pkt_count + 32'd1;
      if (s2_sat)      sat_flag  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nukv_rotation_stream.sv
// Directed bench for nukv_rotation_stream: vector table streamed through a scoreboard,
// plus hand sequences for latency, backpressure and mid-packet reset.
module tb_nukv_rotation_stream;

  localparam logic [63:0] K = 64'h10000;
  localparam logic [127:0] U = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_FACE;
  localparam logic [63:0] PMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NMIN = 64'h8000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic [575:0] matrix_data;
  logic         matrix_valid;
  logic         bypass;
  logic [511:0] input_data;
  logic         input_valid;
  logic         input_last;
  logic         input_ready;
  logic [511:0] output_data;
  logic         output_valid;
  logic         output_last;
  logic         output_ready;
  logic [31:0]  pkt_count;
  logic         sat_flag;

  nukv_rotation_stream dut (
    .clk(clk), .rst(rst),
    .matrix_data(matrix_data), .matrix_valid(matrix_valid), .bypass(bypass),
    .input_data(input_data), .input_valid(input_valid), .input_last(input_last),
    .input_ready(input_ready),
    .output_data(output_data), .output_valid(output_valid), .output_last(output_last),
    .output_ready(output_ready),
    .pkt_count(pkt_count), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] din;
    logic         last;
    logic         byp;
    logic         mv;
    logic [575:0] mat;
    logic [511:0] exp;
  } vec_t;

  typedef struct {
    logic [511:0] d;
    logic         l;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b1;
  logic rnd_ready = 1'b0;

  logic [575:0] idm, zrot, d2;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", nm);
  endtask

  function automatic logic [511:0] mk(input logic [63:0] a0, a1, a2, b0, b1, b2,
                                      input logic [127:0] up);
    return {up, b2, b1, b0, a2, a1, a0};
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic add(input logic [511:0] din, input logic last, input logic byp,
                     input logic mv, input logic [575:0] mat, input logic [511:0] exp);
    vec_t v;
    v.din = din; v.last = last; v.byp = byp; v.mv = mv; v.mat = mat; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send(input logic [511:0] d, input logic l, input logic b,
                      input logic mv, input logic [575:0] m);
    input_data  = d;
    input_last  = l;
    bypass      = b;
    input_valid = 1'b1;
    matrix_valid = mv;
    if (mv) matrix_data = m;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (input_ready) break;
      if (t > 500) begin
        timeout("send");
        break;
      end
    end
    @(posedge clk);
    #1;
    input_valid  = 1'b0;
    matrix_valid = 1'b0;
    bypass       = 1'b0;
    input_last   = 1'b0;
  endtask

  task automatic load(input logic [575:0] m);
    matrix_data  = m;
    matrix_valid = 1'b1;
    @(posedge clk);
    #1;
    matrix_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [511:0] d, input logic l);
    exp_t e;
    e.d = d; e.l = l;
    exp_q.push_back(e);
  endtask

  // Random consumer readiness while enabled.
  always @(posedge clk) begin
    #1;
    if (rnd_ready) output_ready = ($urandom_range(0, 1) == 1);
  end

  // Scoreboard and stall-stability monitor.
  logic         stalled = 1'b0;
  logic [511:0] held_d;
  logic         held_l;
  always @(negedge clk) begin
    if (!mon_en) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", {511'd0, output_valid}, 512'd1);
        chk("stall_data", output_data, held_d);
        chk("stall_last", {511'd0, output_last}, {511'd0, held_l});
      end
      if (output_valid && output_ready) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_output");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", output_data, e.d);
          chk("out_last", {511'd0, output_last}, {511'd0, e.l});
        end
      end
      stalled = output_valid && !output_ready;
      held_d  = output_data;
      held_l  = output_last;
    end
  end

  initial begin
    logic [511:0] h, w1, w2, d;
    int len;

    idm = '0; zrot = '0; d2 = '0;
    for (int i = 0; i < 3; i++) begin
      idm[(i*3+i)*64 +: 64] = K;
      d2[(i*3+i)*64 +: 64]  = 2 * K;
    end
    zrot[(0*3+1)*64 +: 64] = -K;
    zrot[(1*3+0)*64 +: 64] = K;
    zrot[(2*3+2)*64 +: 64] = K;

    rst = 1'b1; matrix_data = '0; matrix_valid = 1'b0; bypass = 1'b0;
    input_data = '0; input_valid = 1'b0; input_last = 1'b0; output_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {511'd0, output_valid}, 512'd0);
    chk("rst_last", {511'd0, output_last}, 512'd0);
    chk("rst_data", output_data, 512'd0);
    chk("rst_pkt_count", {480'd0, pkt_count}, 512'd0);
    chk("rst_sat", {511'd0, sat_flag}, 512'd0);
    chk("rst_in_ready", {511'd0, input_ready}, 512'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Identity after reset, with 2-cycle latency check on the header word
    h  = mk(64'h08, 64'h1111, 64'h2222, 64'h3, 64'h4, 64'h5, U);
    w1 = mk(3*K, 5*K, 7*K, -K, 64'd0, 2*K, U);
    w2 = mk(PMAX, NMIN, 64'd1, -64'd1, 64'd123, -64'd456, ~U);
    push(h, 1'b0); push(w1, 1'b0); push(w2, 1'b1);
    send(h, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("latency_c1_valid", {511'd0, output_valid}, 512'd0);
    @(negedge clk);
    chk("latency_c2_valid", {511'd0, output_valid}, 512'd1);
    @(posedge clk);
    #1;
    send(w1, 1'b0, 1'b0, 1'b0, '0);
    send(w2, 1'b1, 1'b0, 1'b0, '0);
    drain();
    chk("ident_pkt_count", {480'd0, pkt_count}, 512'd1);
    chk("ident_sat", {511'd0, sat_flag}, 512'd0);

    // Vector table: Z rotation, mid-packet strobe, saturation, bypass, single word
    load(zrot);
    h = mk(64'h08, 64'h1111, 64'h2222, 64'h3, 64'h4, 64'h5, U);
    add(h, 1'b0, 1'b0, 1'b0, '0, h);
    add(mk(3*K, 5*K, 7*K, -K, 64'd0, 2*K, U), 1'b1, 1'b0, 1'b0, '0,
        mk(-5*K, 3*K, 7*K, 64'd0, -K, 2*K, U));
    // packet A: strobe diag(2) on body word 2, Z stays active
    h = mk(64'h0A, 64'h9, 64'h8, 64'h7, 64'h6, 64'h5, U);
    add(h, 1'b0, 1'b0, 1'b0, '0, h);
    add(mk(3*K, 5*K, 7*K, -K, 64'd0, 2*K, U), 1'b0, 1'b0, 1'b0, '0,
        mk(-5*K, 3*K, 7*K, 64'd0, -K, 2*K, U));
    add(mk(K, 2*K, 3*K, 64'd0, 64'd0, 64'd0, 128'd0), 1'b0, 1'b0, 1'b1, d2,
        mk(-2*K, K, 3*K, 64'd0, 64'd0, 64'd0, 128'd0));
    add(mk(4*K, 64'd0, 64'd0, 64'd0, 64'd0, K, U), 1'b1, 1'b0, 1'b0, '0,
        mk(64'd0, 4*K, 64'd0, 64'd0, 64'd0, K, U));
    // packet B: diag(2) with positive and negative clamps
    h = mk(64'h0B, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, U);
    add(h, 1'b0, 1'b0, 1'b0, '0, h);
    add(mk(3*K, 5*K, 7*K, PMAX, NMIN, 64'd5, U), 1'b1, 1'b0, 1'b0, '0,
        mk(6*K, 10*K, 14*K, PMAX, NMIN, 64'd10, U));
    // packet C: bypass
    h = mk(64'h0C, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, U);
    add(h, 1'b0, 1'b1, 1'b0, '0, h);
    add(mk(3*K, 5*K, 7*K, -K, 64'd0, 2*K, U), 1'b1, 1'b0, 1'b0, '0,
        mk(3*K, 5*K, 7*K, -K, 64'd0, 2*K, U));
    // single-word packet
    h = mk(64'h0D, K, K, K, K, K, U);
    add(h, 1'b1, 1'b0, 1'b0, '0, h);
    // packet D: bypass no longer in effect
    h = mk(64'h0E, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, U);
    add(h, 1'b0, 1'b0, 1'b0, '0, h);
    add(mk(K, K, K, -K, -K, -K, U), 1'b1, 1'b0, 1'b0, '0,
        mk(2*K, 2*K, 2*K, -2*K, -2*K, -2*K, U));

    for (int k = 0; k < tbl.size(); k++) begin
      push(tbl[k].exp, tbl[k].last);
      send(tbl[k].din, tbl[k].last, tbl[k].byp, tbl[k].mv, tbl[k].mat);
    end
    drain();
    chk("table_pkt_count", {480'd0, pkt_count}, 512'd7);
    chk("table_sat", {511'd0, sat_flag}, 512'd1);

    // Backpressure: 20 random packets under identity, random output_ready
    load(idm);
    rnd_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 4);
      for (int w = 0; w < len; w++) begin
        d = rnd512();
        push(d, (w == len - 1));
        send(d, (w == len - 1), 1'b0, 1'b0, '0);
      end
    end
    drain();
    rnd_ready = 1'b0;
    output_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_pkt_count", {480'd0, pkt_count}, 512'd27);
    chk("bp_sat_sticky", {511'd0, sat_flag}, 512'd1);

    // Reset mid-packet: Z becomes active, then reset drops it
    load(zrot);
    mon_en = 1'b0;
    send(mk(64'h0F, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, U), 1'b0, 1'b0, 1'b0, '0);
    send(mk(3*K, 5*K, 7*K, -K, 64'd0, 2*K, U), 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_valid", {511'd0, output_valid}, 512'd0);
    chk("midrst_pkt_count", {480'd0, pkt_count}, 512'd0);
    chk("midrst_sat", {511'd0, sat_flag}, 512'd0);
    exp_q.delete();
    mon_en = 1'b1;
    h  = mk(64'h10, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, U);
    w1 = mk(3*K, 5*K, 7*K, -K, 64'd0, 2*K, U);
    push(h, 1'b0); push(w1, 1'b1);
    send(h, 1'b0, 1'b0, 1'b0, '0);
    send(w1, 1'b1, 1'b0, 1'b0, '0);
    drain();
    chk("postrst_pkt_count", {480'd0, pkt_count}, 512'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
